// File: rtl/homeostat_pkg.sv
// Shared types and helpers for the homeostatic drive bank: level encoding,
// raw-level extraction and the saturating net-delta clamp.
package homeostat_pkg;

  // Widest counter the helper functions accept.
  localparam int MAX_W = 16;

  typedef enum logic [1:0] {
    LVL_LOW   = 2'd0,
    LVL_MIDLO = 2'd1,
    LVL_MIDHI = 2'd2,
    LVL_HIGH  = 2'd3
  } lvl_e;

  // Top two bits of a w-bit value.
  function automatic lvl_e lvl_of_raw(input logic [MAX_W-1:0] value, input int w);
    return lvl_e'(value[w-2 +: 2]);
  endfunction

  // value + delta, clamped to 0 .. 2^w-1. The sum is carried in an int, so
  // an intermediate of -2 .. 2^w+1 never wraps.
  function automatic logic [MAX_W-1:0] clamp_delta(input logic [MAX_W-1:0] value,
                                                   input logic signed [2:0] delta,
                                                   input int w);
    int sum;
    int top;
    sum = int'(value) + int'(delta);
    top = (1 << w) - 1;
    if (sum < 0)   return '0;
    if (sum > top) return MAX_W'(top);
    return MAX_W'(sum);
  endfunction

endpackage

// File: rtl/homeostat_bank_if.sv
// Host-side bundle of the homeostat bank: step/stimulus/load inputs and the
// per-channel value, level and status outputs.
interface homeostat_bank_if #(
  parameter int NUM_CH = 3,
  parameter int W      = 7
);
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                  tick;
  logic [NUM_CH-1:0]     inc;
  logic [NUM_CH-1:0]     dec;
  logic [NUM_CH-1:0]     leak_en;
  logic                  ld_valid;
  logic [CW-1:0]         ld_ch;
  logic [W-1:0]          ld_val;
  logic [NUM_CH*W-1:0]   value;
  logic [NUM_CH*2-1:0]   level;
  logic [NUM_CH-1:0]     level_chg;
  logic [NUM_CH-1:0]     saturated;
  logic                  depleted;

  modport master (
    output tick, inc, dec, leak_en, ld_valid, ld_ch, ld_val,
    input  value, level, level_chg, saturated, depleted
  );

  modport slave (
    input  tick, inc, dec, leak_en, ld_valid, ld_ch, ld_val,
    output value, level, level_chg, saturated, depleted
  );
endinterface

// File: rtl/homeostat_channel.sv
// One homeostatic drive: saturating counter with load override and a
// hysteretic 2-bit level classifier that runs every clock.
module homeostat_channel
  import homeostat_pkg::*;
#(
  parameter int         W       = 7,
  parameter logic [W-1:0] DEFAULT = '0,
  parameter int         HYST    = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         step_en_i,
  input  logic         inc_i,
  input  logic         dec_i,
  input  logic         leak_i,
  input  logic         ld_en_i,
  input  logic [W-1:0] ld_val_i,
  output logic [W-1:0] value_o,
  output lvl_e         level_o,
  output logic         level_chg_o,
  output logic         saturated_o
);

  localparam int   Q       = 1 << (W - 2);
  localparam lvl_e RST_LVL = lvl_of_raw(MAX_W'(DEFAULT), W);

  logic [W-1:0]      value_q, value_d;
  lvl_e              level_q, level_d;
  logic              chg_q;
  logic signed [2:0] delta;
  logic [MAX_W-1:0]  sum_w;

  always_comb begin
    // NOTE: every variable gets its default first, so no path can leave one
    // unassigned and infer a latch.
    delta = 3'sd0;
    if (inc_i) delta = delta + 3'sd1;
    if (dec_i) delta = delta - 3'sd1;
    if (leak_i && (value_q < DEFAULT))      delta = delta + 3'sd1;
    else if (leak_i && (value_q > DEFAULT)) delta = delta - 3'sd1;

    sum_w   = clamp_delta(MAX_W'(value_q), delta, W);
    value_d = value_q;
    if (ld_en_i)        value_d = ld_val_i;
    else if (step_en_i) value_d = sum_w[W-1:0];
  end

  // Thresholds sit HYST counts past each quarter boundary, one step per clock.
  always_comb begin
    int v;
    int l;
    v       = int'(value_q);
    l       = int'(level_q);
    level_d = level_q;
    if ((l < 3) && (v >= (l + 1) * Q + HYST))  level_d = lvl_e'(level_q + 2'd1);
    else if ((l > 0) && (v < l * Q - HYST))     level_d = lvl_e'(level_q - 2'd1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= DEFAULT;
      level_q <= RST_LVL;
      chg_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge state regardless of statement order.
      value_q <= value_d;
      level_q <= level_d;
      chg_q   <= (level_d != level_q);
    end
  end

  assign value_o     = value_q;
  assign level_o     = level_q;
  assign level_chg_o = chg_q;
  assign saturated_o = (value_q == '0) || (value_q == '1);

endmodule

// File: rtl/homeostat_bank.sv
// Bank of NUM_CH homeostatic drives sharing one leak timer; channel 0 is the
// vital drive whose depletion freezes the whole bank until reset.
module homeostat_bank
  import homeostat_pkg::*;
#(
  parameter int                 NUM_CH       = 3,
  parameter int                 W            = 7,
  parameter logic [NUM_CH*W-1:0] DEFAULT_VALS = {7'd96, 7'd0, 7'd64},
  parameter int                 LEAK_PERIOD  = 16,
  parameter int                 HYST         = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  homeostat_bank_if.slave  bus
);

  localparam int TW = (LEAK_PERIOD > 1) ? $clog2(LEAK_PERIOD) : 1;

  logic [TW-1:0]     tmr_q, tmr_d;
  logic              depleted_q, depleted_d;
  logic              step_en;
  logic              leak_stb;
  logic [W-1:0]      val_arr [NUM_CH];
  lvl_e              lvl_arr [NUM_CH];
  logic [NUM_CH-1:0] chg_vec;
  logic [NUM_CH-1:0] sat_vec;

  // A depleted bank stops stepping, leaking and loading.
  assign step_en  = bus.tick && !depleted_q;
  assign leak_stb = step_en && (tmr_q == TW'(LEAK_PERIOD - 1));

  always_comb begin
    tmr_d = tmr_q;
    if (step_en) tmr_d = leak_stb ? '0 : tmr_q + TW'(1);
    depleted_d = depleted_q || (val_arr[0] == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr_q      <= '0;
      depleted_q <= 1'b0;
    end else begin
      tmr_q      <= tmr_d;
      depleted_q <= depleted_d;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic ld_hit;
    assign ld_hit = bus.ld_valid && !depleted_q && (int'(bus.ld_ch) == i);

    homeostat_channel #(
      .W       (W),
      .DEFAULT (DEFAULT_VALS[i*W +: W]),
      .HYST    (HYST)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .step_en_i   (step_en),
      .inc_i       (bus.inc[i]),
      .dec_i       (bus.dec[i]),
      .leak_i      (leak_stb && bus.leak_en[i]),
      .ld_en_i     (ld_hit),
      .ld_val_i    (bus.ld_val),
      .value_o     (val_arr[i]),
      .level_o     (lvl_arr[i]),
      .level_chg_o (chg_vec[i]),
      .saturated_o (sat_vec[i])
    );
  end

  always_comb begin
    bus.value = '0;
    bus.level = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      bus.value[i*W +: W] = val_arr[i];
      bus.level[2*i +: 2] = lvl_arr[i];
    end
  end

  assign bus.level_chg = chg_vec;
  assign bus.saturated = sat_vec;
  assign bus.depleted  = depleted_q;

endmodule

// File: tb/tb_homeostat_bank.sv
// Self-checking bench for homeostat_bank: directed scenarios plus random
// stimulus, all compared against an integer reference model of the drives.
module tb_homeostat_bank;

  localparam int NUM_CH = 3;
  localparam int W      = 7;
  localparam int LP     = 4;
  localparam int HYST   = 2;
  localparam int Q      = 32;
  localparam int VMAX   = 127;
  localparam logic [NUM_CH*W-1:0] DEF = {7'd96, 7'd0, 7'd64};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  homeostat_bank_if #(.NUM_CH(NUM_CH), .W(W)) bus ();

  homeostat_bank #(
    .NUM_CH       (NUM_CH),
    .W            (W),
    .DEFAULT_VALS (DEF),
    .LEAK_PERIOD  (LP),
    .HYST         (HYST)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  int m_val [NUM_CH];
  int m_lvl [NUM_CH];
  int m_chg [NUM_CH];
  int m_dep;
  int m_tmr;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int def_of(input int i);
    logic [NUM_CH*W-1:0] d;
    d = DEF;
    return int'(d[i*W +: W]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_val[i] = def_of(i);
      m_lvl[i] = def_of(i) / Q;
      m_chg[i] = 0;
    end
    m_dep = 0;
    m_tmr = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_clock();
    int  ndep;
    int  nl;
    int  nv;
    int  d;
    bit  stb;
    ndep = (m_dep != 0 || m_val[0] == 0) ? 1 : 0;
    stb  = bus.tick && m_dep == 0 && m_tmr == LP - 1;
    if (bus.tick && m_dep == 0) m_tmr = (m_tmr + 1) % LP;
    for (int i = 0; i < NUM_CH; i++) begin
      nl = m_lvl[i];
      if (m_lvl[i] < 3 && m_val[i] >= (m_lvl[i] + 1) * Q + HYST)  nl = m_lvl[i] + 1;
      else if (m_lvl[i] > 0 && m_val[i] < m_lvl[i] * Q - HYST)    nl = m_lvl[i] - 1;
      m_chg[i] = (nl != m_lvl[i]) ? 1 : 0;
      m_lvl[i] = nl;

      nv = m_val[i];
      if (m_dep == 0) begin
        if (bus.ld_valid && int'(bus.ld_ch) == i) begin
          nv = int'(bus.ld_val);
        end else if (bus.tick) begin
          d = int'(bus.inc[i]) - int'(bus.dec[i]);
          if (stb && bus.leak_en[i]) begin
            if (m_val[i] < def_of(i))      d = d + 1;
            else if (m_val[i] > def_of(i)) d = d - 1;
          end
          nv = m_val[i] + d;
          if (nv < 0)    nv = 0;
          if (nv > VMAX) nv = VMAX;
        end
      end
      m_val[i] = nv;
    end
    m_dep = ndep;
  endtask

  task automatic compare_all();
    logic [NUM_CH*W-1:0] ev;
    logic [2*NUM_CH-1:0] el;
    logic [NUM_CH-1:0]   ec;
    logic [NUM_CH-1:0]   es;
    for (int i = 0; i < NUM_CH; i++) begin
      ev[i*W +: W] = W'(m_val[i]);
      el[2*i +: 2] = 2'(m_lvl[i]);
      ec[i]        = (m_chg[i] != 0);
      es[i]        = (m_val[i] == 0 || m_val[i] == VMAX);
    end
    check("value",     64'(bus.value),     64'(ev));
    check("level",     64'(bus.level),     64'(el));
    check("level_chg", 64'(bus.level_chg), 64'(ec));
    check("saturated", 64'(bus.saturated), 64'(es));
    check("depleted",  64'(bus.depleted),  64'(m_dep));
  endtask

  task automatic idle_inputs();
    bus.tick     = 1'b0;
    bus.inc      = '0;
    bus.dec      = '0;
    bus.leak_en  = '0;
    bus.ld_valid = 1'b0;
    bus.ld_ch    = '0;
    bus.ld_val   = '0;
  endtask

  task automatic step();
    @(posedge clk);
    model_clock();
    #1;
    compare_all();
  endtask

  // Called 1 time unit after a rising edge; reset is checked before any edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    model_reset();
    compare_all();
    check("rst_value", 64'(bus.value), 64'({7'd96, 7'd0, 7'd64}));
    check("rst_level", 64'(bus.level), 64'(6'b11_00_10));
    #1;
    rst_n = 1'b1;
  endtask

  task automatic load(input int ch, input int val);
    bus.ld_valid = 1'b1;
    bus.ld_ch    = 2'(ch);
    bus.ld_val   = W'(val);
    step();
    bus.ld_valid = 1'b0;
  endtask

  initial begin
    idle_inputs();
    model_reset();
    @(posedge clk);
    #1;
    do_reset();
    check("rst_depleted", 64'(bus.depleted), 64'd0);
    check("rst_chg",      64'(bus.level_chg), 64'd0);

    // Saturation, then inc+dec cancel.
    bus.tick = 1'b1;
    bus.inc  = 3'b100;
    repeat (40) step();
    check("sat_value2", 64'(bus.value[20:14]), 64'd127);
    check("sat_flag2",  64'(bus.saturated[2]), 64'd1);
    bus.dec = 3'b100;
    repeat (5) step();
    check("cancel_value2", 64'(bus.value[20:14]), 64'd127);

    // Leak toward resting value; channel 0 already sits at its default.
    idle_inputs();
    load(1, 10);
    bus.tick    = 1'b1;
    bus.leak_en = 3'b011;
    repeat (12) step();
    check("leak_value1", 64'(bus.value[13:7]), 64'd7);
    check("leak_rest0",  64'(bus.value[6:0]),  64'd64);

    // Hysteresis around the 64 boundary of channel 2.
    idle_inputs();
    load(2, 64);
    repeat (3) step();
    check("hys_lvl64", 64'(bus.level[5:4]), 64'd2);
    bus.tick = 1'b1; bus.dec = 3'b100; step();
    idle_inputs(); repeat (3) step();
    check("hys_lvl63", 64'(bus.level[5:4]), 64'd2);
    bus.tick = 1'b1; bus.dec = 3'b100; repeat (2) step();
    idle_inputs(); step();
    check("hys_lvl61", 64'(bus.level[5:4]), 64'd1);
    check("hys_chg61", 64'(bus.level_chg[2]), 64'd1);
    step();
    check("hys_chg_off", 64'(bus.level_chg[2]), 64'd0);
    bus.tick = 1'b1; bus.inc = 3'b100; repeat (4) step();
    idle_inputs(); repeat (3) step();
    check("hys_lvl65", 64'(bus.level[5:4]), 64'd1);
    bus.tick = 1'b1; bus.inc = 3'b100; step();
    idle_inputs(); repeat (3) step();
    check("hys_lvl66", 64'(bus.level[5:4]), 64'd2);

    // Load beats tick arithmetic on its channel only.
    bus.tick     = 1'b1;
    bus.inc      = 3'b111;
    bus.ld_valid = 1'b1;
    bus.ld_ch    = 2'd0;
    bus.ld_val   = 7'd50;
    step();
    check("prio_value0", 64'(bus.value[6:0]), 64'd50);
    idle_inputs();

    // Random stimulus, with periodic resets to revive a depleted bank.
    for (int k = 0; k < 500; k++) begin
      bus.tick     = ($urandom_range(0, 3) != 0);
      bus.inc      = NUM_CH'($urandom);
      bus.dec      = NUM_CH'($urandom);
      bus.leak_en  = NUM_CH'($urandom);
      bus.ld_valid = ($urandom_range(0, 7) == 0);
      bus.ld_ch    = 2'($urandom_range(0, 3));
      bus.ld_val   = W'($urandom);
      step();
      if (k % 100 == 99) begin
        idle_inputs();
        do_reset();
      end
    end
    idle_inputs();
    step();
    do_reset();

    // Depletion: flag one edge after zero, then everything freezes.
    load(0, 1);
    bus.tick = 1'b1; bus.dec = 3'b001; step();
    check("dep_value0", 64'(bus.value[6:0]), 64'd0);
    check("dep_not_yet", 64'(bus.depleted), 64'd0);
    bus.dec = 3'b000; bus.inc = 3'b010; step();
    check("dep_set", 64'(bus.depleted), 64'd1);
    check("dep_last_stim1", 64'(bus.value[13:7]), 64'd1);
    idle_inputs();
    load(0, 20);
    bus.tick = 1'b1; bus.inc = 3'b111; repeat (6) step();
    check("dep_frozen0", 64'(bus.value[6:0]), 64'd0);
    check("dep_sticky", 64'(bus.depleted), 64'd1);
    idle_inputs();
    do_reset();
    check("dep_cleared", 64'(bus.depleted), 64'd0);
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
